// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared glyph geometry, ROM limits and fetch-state encoding for the text pipeline
package vga_text_pkg;

    localparam int GLYPH_ROWS = 7;
    localparam int GLYPH_BITS = 5;
    localparam int CELL_W     = 6;
    localparam int ADDR_W     = 11;
    localparam int CHAR_MAX   = 163;
    localparam int COL_W      = 3;

    typedef enum logic [1:0] {
        F_IDLE,
        F_ADDR,
        F_WAIT
    } fetch_state_t;

    // ROM address of one glyph scanline: glyphs are stored GLYPH_ROWS lines apart
    function automatic logic [ADDR_W-1:0] glyph_addr(input logic [7:0] code, input logic [2:0] row);
        return ADDR_W'(code) * ADDR_W'(GLYPH_ROWS) + ADDR_W'(row);
    endfunction

    // Codes beyond the ROM and rows past the glyph height render as an empty scanline
    function automatic logic glyph_blank(input logic [7:0] code, input logic [2:0] row);
        return (int'(code) > CHAR_MAX) || (int'(row) >= GLYPH_ROWS);
    endfunction

endpackage

// File: rtl/glyph_shifter.sv
// rtl/glyph_shifter.sv - one-entry pending scanline buffer and MSB-first pixel serializer
module glyph_shifter
    import vga_text_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_en,
    input  logic                  load,
    input  logic [GLYPH_BITS-1:0] load_data,
    output logic                  pend_full,
    output logic                  pix_out,
    output logic                  pix_valid,
    output logic                  underflow
);

    logic [GLYPH_BITS-1:0] pend;
    logic [GLYPH_BITS-1:0] shreg;
    logic [COL_W-1:0]      col;
    logic [COL_W-1:0]      col_nx;
    logic [COL_W-1:0]      bit_idx;
    logic                  active;
    logic                  boundary;

    // A cell ends after its last gap column; an idle shifter is always at a boundary
    assign boundary = !active || (col == COL_W'(CELL_W - 1));
    assign col_nx   = col + 3'd1;
    assign bit_idx  = COL_W'(GLYPH_BITS - 1) - col_nx;

    assign pix_valid = active;

    // Pending capture from the fetch side plus per-enable cell serialization
    always_ff @(posedge clk) begin
        if (reset) begin
            pend      <= '0;
            pend_full <= 1'b0;
            shreg     <= '0;
            col       <= '0;
            active    <= 1'b0;
            pix_out   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // A capture only happens while the buffer is empty, so it never races the load below
            if (load) begin
                pend      <= load_data;
                pend_full <= 1'b1;
            end
            if (pix_en) begin
                if (boundary) begin
                    if (pend_full) begin
                        shreg     <= pend;
                        col       <= '0;
                        active    <= 1'b1;
                        pend_full <= 1'b0;
                        pix_out   <= pend[GLYPH_BITS-1];
                    end else begin
                        active  <= 1'b0;
                        pix_out <= 1'b0;
                        if (active) begin
                            underflow <= 1'b1;
                        end
                    end
                end else begin
                    col     <= col_nx;
                    pix_out <= (col_nx < COL_W'(GLYPH_BITS)) ? shreg[bit_idx] : 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/glyph_scan_fetch.sv
// rtl/glyph_scan_fetch.sv - glyph ROM reader: request handshake, one-cycle ROM read, pixel serialization
module glyph_scan_fetch
    import vga_text_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              char_valid,
    input  logic [7:0]        char_code,
    input  logic [2:0]        char_row,
    output logic              char_ready,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [7:0]        rom_dout,
    output logic              pix_out,
    output logic              pix_valid,
    output logic              underflow
);

    fetch_state_t          state;
    logic                  blank_q;
    logic                  pend_full;
    logic                  pend_load;
    logic [GLYPH_BITS-1:0] pend_data;
    logic                  unused_rom_bits;

    // Only the low GLYPH_BITS of each ROM byte carry pixels
    assign unused_rom_bits = ^rom_dout[7:GLYPH_BITS];

    // Accept only when idle and the pending slot is empty; the slot must be free
    // before the fetch starts because the capture has no back-pressure
    assign char_ready = (state == F_IDLE) && !pend_full;

    // Read data is registered in the ROM, so it is valid during F_WAIT
    assign pend_load = (state == F_WAIT);
    assign pend_data = blank_q ? '0 : rom_dout[GLYPH_BITS-1:0];

    // Fetch sequencer: address issue, ROM latency wait, hand-off to the pending buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= F_IDLE;
            rom_ce  <= 1'b0;
            rom_ad  <= '0;
            blank_q <= 1'b0;
        end else begin
            case (state)
                F_IDLE: begin
                    if (char_valid && char_ready) begin
                        rom_ad  <= glyph_addr(char_code, char_row);
                        blank_q <= glyph_blank(char_code, char_row);
                        rom_ce  <= !glyph_blank(char_code, char_row);
                        state   <= F_ADDR;
                    end
                end
                F_ADDR: begin
                    rom_ce <= 1'b0;
                    state  <= F_WAIT;
                end
                F_WAIT: begin
                    state <= F_IDLE;
                end
                default: begin
                    rom_ce <= 1'b0;
                    state  <= F_IDLE;
                end
            endcase
        end
    end

    glyph_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .load      (pend_load),
        .load_data (pend_data),
        .pend_full (pend_full),
        .pix_out   (pix_out),
        .pix_valid (pix_valid),
        .underflow (underflow)
    );

endmodule

// File: tb/tb_glyph_scan_fetch.sv
// tb/tb_glyph_scan_fetch.sv - self-checking bench for glyph_scan_fetch with a charROM model and a queue-based reference
module tb_glyph_scan_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic        char_valid;
    logic [7:0]  char_code;
    logic [2:0]  char_row;
    logic        char_ready;
    logic        rom_ce;
    logic [10:0] rom_ad;
    logic [7:0]  rom_dout;
    logic        pix_out;
    logic        pix_valid;
    logic        underflow;

    int n_checks = 0;
    int n_fail   = 0;

    glyph_scan_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .char_valid (char_valid),
        .char_code  (char_code),
        .char_row   (char_row),
        .char_ready (char_ready),
        .rom_ce     (rom_ce),
        .rom_ad     (rom_ad),
        .rom_dout   (rom_dout),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    // charROM model: registered read on rom_ce
    logic [7:0] rom_mem [0:2047];
    always @(posedge clk) begin
        if (rom_ce) rom_dout <= rom_mem[rom_ad];
    end

    // Reference: a fetch is a 2-edge countdown after the accept edge; a cell is a queue of 6 pixels
    int          m_cnt;
    logic [4:0]  m_fdata;
    logic [4:0]  m_pend;
    bit          m_pf, m_valid, m_pix, m_uf, m_ce;
    logic [10:0] m_ad;
    bit          m_q[$];

    function automatic bit m_ready();
        return (m_cnt == 0) && !m_pf;
    endfunction

    task automatic model_step();
        bit acc;
        bit old_pf;
        int addr;
        bit blank;
        if (reset) begin
            m_cnt = 0; m_pf = 0; m_valid = 0; m_pix = 0; m_uf = 0; m_ce = 0;
            m_ad = '0; m_pend = '0; m_fdata = '0;
            m_q.delete();
            return;
        end
        acc    = char_valid && m_ready();
        old_pf = m_pf;
        if (pix_en) begin
            if (m_q.size() == 0) begin
                if (old_pf) begin
                    for (int i = 4; i >= 0; i--) m_q.push_back(m_pend[i]);
                    m_q.push_back(1'b0);
                    m_pix   = m_q.pop_front();
                    m_valid = 1;
                    m_pf    = 0;
                end else begin
                    if (m_valid) m_uf = 1;
                    m_valid = 0;
                    m_pix   = 0;
                end
            end else begin
                m_pix = m_q.pop_front();
            end
        end
        m_ce = 0;
        if (m_cnt == 1) begin
            m_pend = m_fdata;
            m_pf   = 1;
        end
        if (m_cnt > 0) m_cnt--;
        if (acc) begin
            addr    = int'(char_code) * 7 + int'(char_row);
            blank   = (char_code > 8'd163) || (char_row >= 3'd7);
            m_ad    = 11'(addr);
            m_fdata = blank ? 5'd0 : rom_mem[addr[10:0]][4:0];
            m_ce    = !blank;
            m_cnt   = 2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1; char_valid = 0; pix_en = 0; char_code = '0; char_row = '0;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; char_valid = 0; pix_en = 0; char_code = '0; char_row = '0;
        tick();
        tick();
        n_checks++; if (pix_out !== 1'b0)   begin n_fail++; $display("FAIL reset_pix_out: got %0b expected 0", pix_out); end
        n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid: got %0b expected 0", pix_valid); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %0b expected 0", underflow); end
        n_checks++; if (rom_ce !== 1'b0)    begin n_fail++; $display("FAIL reset_rom_ce: got %0b expected 0", rom_ce); end
        n_checks++; if (rom_ad !== 11'd0)   begin n_fail++; $display("FAIL reset_rom_ad: got %0d expected 0", rom_ad); end
        reset = 0;
        tick();
        n_checks++; if (char_ready !== 1'b1) begin n_fail++; $display("FAIL reset_char_ready: got %0b expected 1", char_ready); end
    endtask

    // Single glyph 0x41 row 2, continuous pix_en, then drain into underflow
    task automatic test_single_glyph();
        logic [5:0] exp_bits;
        exp_bits = 6'b101010;
        do_reset();
        pix_en = 1; char_valid = 1; char_code = 8'h41; char_row = 3'd2;
        n_checks++; if (char_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %0b expected 1", char_ready); end
        tick();
        char_valid = 0;
        n_checks++; if (rom_ce !== 1'b1)   begin n_fail++; $display("FAIL single_rom_ce: got %0b expected 1", rom_ce); end
        n_checks++; if (rom_ad !== 11'd457) begin n_fail++; $display("FAIL single_rom_ad: got %0d expected 457", rom_ad); end
        tick();
        n_checks++; if (rom_ce !== 1'b0)   begin n_fail++; $display("FAIL single_rom_ce_drop: got %0b expected 0", rom_ce); end
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (pix_out !== exp_bits[5-i]) begin n_fail++; $display("FAIL single_pix[%0d]: got %0b expected %0b", i, pix_out, exp_bits[5-i]); end
            n_checks++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid[%0d]: got %0b expected 1", i, pix_valid); end
            n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL single_uf_early[%0d]: got %0b expected 0", i, underflow); end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid[%0d]: got %0b expected 0", i, pix_valid); end
            n_checks++; if (pix_out !== 1'b0)   begin n_fail++; $display("FAIL drain_pix[%0d]: got %0b expected 0", i, pix_out); end
            n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL drain_underflow[%0d]: got %0b expected 1", i, underflow); end
            tick();
        end
    endtask

    // 0x41 then 0x42, row 0, request held valid: second cell must follow with no gap
    task automatic test_back_to_back();
        bit exp_valid;
        do_reset();
        pix_en = 1; char_valid = 1; char_code = 8'h41; char_row = 3'd0;
        tick();
        char_code = 8'h42;
        n_checks++; if (rom_ad !== 11'd455) begin n_fail++; $display("FAIL b2b_rom_ad0: got %0d expected 455", rom_ad); end
        for (int cyc = 2; cyc <= 17; cyc++) begin
            tick();
            if (cyc == 5) begin
                char_valid = 0;
                n_checks++; if (rom_ce !== 1'b1)   begin n_fail++; $display("FAIL b2b_rom_ce1: got %0b expected 1", rom_ce); end
                n_checks++; if (rom_ad !== 11'd462) begin n_fail++; $display("FAIL b2b_rom_ad1: got %0d expected 462", rom_ad); end
            end
            exp_valid = (cyc >= 4) && (cyc <= 15);
            n_checks++; if (pix_valid !== exp_valid) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %0b expected %0b", cyc, pix_valid, exp_valid); end
            n_checks++; if (pix_out !== m_pix) begin n_fail++; $display("FAIL b2b_pix[%0d]: got %0b expected %0b", cyc, pix_out, m_pix); end
            n_checks++; if (underflow !== (cyc >= 16)) begin n_fail++; $display("FAIL b2b_underflow[%0d]: got %0b expected %0b", cyc, underflow, cyc >= 16); end
        end
    endtask

    // Out-of-range code or row: no ROM access, six blank pixels, same latency
    task automatic test_blank();
        logic [7:0] codes [2];
        logic [2:0] rows [2];
        codes[0] = 8'd200; rows[0] = 3'd1;
        codes[1] = 8'h41;  rows[1] = 3'd7;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            pix_en = 1; char_valid = 1; char_code = codes[k]; char_row = rows[k];
            tick();
            char_valid = 0;
            n_checks++; if (rom_ce !== 1'b0) begin n_fail++; $display("FAIL blank_rom_ce[%0d]: got %0b expected 0", k, rom_ce); end
            tick();
            tick();
            n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL blank_early_valid[%0d]: got %0b expected 0", k, pix_valid); end
            tick();
            for (int i = 0; i < 6; i++) begin
                n_checks++; if (pix_valid !== 1'b1 || pix_out !== 1'b0) begin n_fail++; $display("FAIL blank_pix[%0d][%0d]: got valid=%0b pix=%0b expected valid=1 pix=0", k, i, pix_valid, pix_out); end
                tick();
            end
            n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL blank_end_valid[%0d]: got %0b expected 0", k, pix_valid); end
        end
    endtask

    // pix_en high one cycle in four: each pixel held four cycles
    task automatic test_slow_pix();
        logic [5:0] exp_bits;
        int nvalid;
        exp_bits = 6'b101010;
        nvalid = 0;
        do_reset();
        char_valid = 1; char_code = 8'h41; char_row = 3'd2; pix_en = 1;
        for (int cyc = 0; cyc < 36; cyc++) begin
            pix_en = (cyc % 4 == 0);
            tick();
            char_valid = 0;
            n_checks++; if (char_ready !== m_ready()) begin n_fail++; $display("FAIL slow_ready[%0d]: got %0b expected %0b", cyc, char_ready, m_ready()); end
            n_checks++; if (pix_out !== m_pix || pix_valid !== m_valid) begin n_fail++; $display("FAIL slow_pix[%0d]: got pix=%0b valid=%0b expected pix=%0b valid=%0b", cyc, pix_out, pix_valid, m_pix, m_valid); end
            if (pix_valid === 1'b1 && nvalid < 24) begin
                n_checks++; if (pix_out !== exp_bits[5 - nvalid/4]) begin n_fail++; $display("FAIL slow_seq[%0d]: got %0b expected %0b", nvalid, pix_out, exp_bits[5 - nvalid/4]); end
                nvalid++;
            end else if (pix_valid === 1'b1) begin
                nvalid++;
            end
        end
        n_checks++; if (nvalid != 24) begin n_fail++; $display("FAIL slow_valid_count: got %0d expected 24", nvalid); end
    endtask

    // Reset while the read is in F_ADDR: the returning ROM data must be dropped
    task automatic test_reset_mid_fetch();
        do_reset();
        pix_en = 1; char_valid = 1; char_code = 8'h41; char_row = 3'd2;
        tick();
        char_valid = 0;
        reset = 1;
        tick();
        reset = 0;
        n_checks++; if (rom_ce !== 1'b0 || rom_ad !== 11'd0) begin n_fail++; $display("FAIL mid_rom: got ce=%0b ad=%0d expected ce=0 ad=0", rom_ce, rom_ad); end
        n_checks++; if (pix_out !== 1'b0 || pix_valid !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL mid_outputs: got pix=%0b valid=%0b uf=%0b expected 0", pix_out, pix_valid, underflow); end
        n_checks++; if (char_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %0b expected 1", char_ready); end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if (pix_valid !== 1'b0 || char_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after[%0d]: got valid=%0b ready=%0b expected valid=0 ready=1", i, pix_valid, char_ready); end
        end
    endtask

    // Random traffic against the reference model
    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset      = ($urandom_range(0, 599) == 0);
            pix_en     = ($urandom_range(0, 3) != 0);
            char_valid = ($urandom_range(0, 2) != 0);
            char_code  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(164, 255)) : 8'($urandom_range(0, 163));
            char_row   = ($urandom_range(0, 11) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            tick();
            n_checks++; if (char_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %0b expected %0b", cyc, char_ready, m_ready()); end
            n_checks++; if (rom_ce !== m_ce) begin n_fail++; $display("FAIL rnd_rom_ce[%0d]: got %0b expected %0b", cyc, rom_ce, m_ce); end
            n_checks++; if (rom_ad !== m_ad) begin n_fail++; $display("FAIL rnd_rom_ad[%0d]: got %0d expected %0d", cyc, rom_ad, m_ad); end
            n_checks++; if (pix_out !== m_pix) begin n_fail++; $display("FAIL rnd_pix_out[%0d]: got %0b expected %0b", cyc, pix_out, m_pix); end
            n_checks++; if (pix_valid !== m_valid) begin n_fail++; $display("FAIL rnd_pix_valid[%0d]: got %0b expected %0b", cyc, pix_valid, m_valid); end
            n_checks++; if (underflow !== m_uf) begin n_fail++; $display("FAIL rnd_underflow[%0d]: got %0b expected %0b", cyc, underflow, m_uf); end
        end
        reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
        rom_mem[457] = 8'b00010101;
        reset = 1; pix_en = 0; char_valid = 0; char_code = '0; char_row = '0;
        @(negedge clk);
        test_reset();
        test_single_glyph();
        test_back_to_back();
        test_blank();
        test_slow_pix();
        test_reset_mid_fetch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/glyph_scan_fetch.md
Name: glyph_scan_fetch

Overview:
- Consumer (reader) side of the character-glyph ROM in the VGA text pipeline.
- Accepts a character code plus glyph scanline index from the text-buffer scanner and issues a one-cycle ROM read (ce/ad, registered data out one cycle later).
- Captures the 5-bit scanline into a one-entry pending buffer, then serializes it MSB-first, plus gap columns, one pixel per pixel-clock enable.
- Fetch of cell N+1 overlaps shifting of cell N.

Parameters:
- GLYPH_ROWS, 7: scanlines per glyph; ROM stride per character.
- GLYPH_BITS, 5: valid pixel bits per scanline, in rom_dout[GLYPH_BITS-1:0].
- CELL_W, 6: pixels per character cell; CELL_W-GLYPH_BITS gap columns, always 0.
- ADDR_W, 11: ROM address width.
- CHAR_MAX, 163: highest code present in ROM (163*7+6 = 1147 < 1152).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- pix_en, in, 1: pixel-clock enable; one pixel advances per high cycle.
- char_valid, in, 1: request valid.
- char_code, in, 8: character code.
- char_row, in, 3: glyph scanline, 0..GLYPH_ROWS-1.
- char_ready, out, 1: request accepted when char_valid && char_ready.
- rom_ce, out, 1: ROM read enable.
- rom_ad, out, ADDR_W: ROM address.
- rom_dout, in, 8: ROM registered read data.
- pix_out, out, 1: serialized pixel.
- pix_valid, out, 1: a glyph cell is currently being shifted.
- underflow, out, 1: sticky; cell boundary reached with no glyph pending.

Behaviour:
- Reset values: all outputs 0 (char_ready is combinational and reads 1 after reset). Reset also sets fetch FSM to F_IDLE, pend_full=0, active=0, col=0, shreg=0.
- Reset mid-fetch discards the in-flight read; a rom_dout arriving after reset is ignored.
- Fetch FSM states:
  - F_IDLE: char_ready = !pend_full. On accept (cycle T), register addr = char_code*GLYPH_ROWS + char_row (ADDR_W bits, unsigned) and set blank = (char_code > CHAR_MAX) || (char_row >= GLYPH_ROWS). Go to F_ADDR.
  - F_ADDR (T+1): rom_ce = !blank, rom_ad = addr. Go to F_WAIT.
  - F_WAIT (T+2): pend = blank ? 0 : rom_dout[GLYPH_BITS-1:0]; pend_full=1 at T+3. Go to F_IDLE.
- rom_ce is asserted only in F_ADDR. rom_ad holds its last value elsewhere; it reads 0 after reset.
- Request-to-pend latency is fixed at 3 cycles, including the blank path.
- Shifter, evaluated only when pix_en=1:
  - Boundary = !active || col==CELL_W-1.
  - At a boundary with pend_full=1: shreg=pend, col=0, active=1, pend_full cleared, pix_out=pend[GLYPH_BITS-1].
  - At a boundary with pend_full=0: active=0, pix_out=0. If active was 1, set underflow.
  - Otherwise: col=col+1, pix_out = shreg[GLYPH_BITS-1-(col+1)] when col+1 < GLYPH_BITS, else 0.
- pix_valid = active, registered with pix_out.
- pix_out, pix_valid and col hold when pix_en=0.
- Simultaneous F_WAIT capture and shifter boundary: the shifter uses the registered pend_full, so there is no bypass. The load happens on the next boundary, and underflow is flagged if active.
- pend_full clear and a new accept in the same cycle: char_ready uses the pre-clear pend_full, so the accept lands one cycle later.
- underflow clears only on reset.

Decomposition:
- Shared package (vga_text_pkg): GLYPH_ROWS, GLYPH_BITS, CELL_W, CHAR_MAX, ADDR_W; fetch-state enum {F_IDLE, F_ADDR, F_WAIT}.
- One natural sub-module: glyph_shifter (pend buffer plus serializer), with the fetch FSM in the top.
- Bench reuses the existing charROM simulation model connected to rom_ce/rom_ad/rom_dout.

Test Plan:
1. Request code 0x41, row 2, with ROM[457] = 8'b00010101 and pix_en=1 continuously -> rom_ce=1 and rom_ad=11'd457 at T+1; pix_out sequence 1,0,1,0,1,0; pix_valid=1 for 6 cycles.
2. Back-to-back codes 0x41 then 0x42, both row 0 -> rom_ad 455 then 462; second glyph starts on the cycle after col 5 with no gap; underflow stays 0.
3. Code 200, or row 7 -> rom_ce stays 0; six zero pixels with pix_valid=1; latency still 3 cycles.
4. pix_en toggled 1-of-4 cycles -> pixel sequence same as scenario 1, each value held for 4 cycles; char_ready=0 while pend_full=1.
5. Single request, then no more -> after 6 pixels, pix_valid=0, pix_out=0, underflow=1 and held.
6. reset asserted in F_ADDR -> next cycle all outputs 0, char_ready=1, rom_ce=0; subsequent rom_dout is not captured.
